// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared widths, opcode encoding and shifter mode encoding
//                for the registered 8-bit datapath ALU.
//  Contents    : REG_WIDTH, OP_WIDTH, alu_op_t, shift_kind_t
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int REG_WIDTH = 8;
  localparam int OP_WIDTH  = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SLL = 3'd2,
    OP_SRL = 3'd3,
    OP_SRA = 3'd4,
    OP_AND = 3'd5,
    OP_XOR = 3'd6,
    OP_BEQ = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_LEFT = 2'd0,
    SH_SRL  = 2'd1,
    SH_SRA  = 2'd2
  } shift_kind_t;

endpackage
`default_nettype wire

// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_if
//  Description : Operand/opcode inputs and registered result outputs of the
//                ALU, bundled for connection between the register-file read
//                side (master) and the ALU (slave).
//  Signals     : ra_in, rb_in  operands A and B
//                op            operation select
//                res_out       primary result
//                car_out       carry/borrow or shifted-out bits
//                zero          result-is-zero flag
//                jump          branch-taken flag
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_if #(
  parameter int REG_W = alu_pkg::REG_WIDTH,
  parameter int OP_W  = alu_pkg::OP_WIDTH
);

  logic [REG_W-1:0] ra_in;
  logic [REG_W-1:0] rb_in;
  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] res_out;
  logic [REG_W-1:0] car_out;
  logic             zero;
  logic             jump;

  modport master (
    output ra_in, rb_in, op,
    input  res_out, car_out, zero, jump
  );

  modport slave (
    input  ra_in, rb_in, op,
    output res_out, car_out, zero, jump
  );

endinterface
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_shifter
//  Description : Combinational 2W-bit barrel shifter. The operand is placed
//                in the half of a 2W-bit word that keeps the shifted-out
//                bits in the other half, so the caller gets {car, res}
//                directly. Shift amount saturates at 2W.
//  Ports       : data    operand (W bits)
//                amount  unsigned shift amount (W bits)
//                kind    left / logical right / arithmetic right
//                word    {car, res} (2W bits)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_shifter
  import alu_pkg::*;
#(
  parameter int REG_W = REG_WIDTH
) (
  input  logic [REG_W-1:0]   data,
  input  logic [REG_W-1:0]   amount,
  input  shift_kind_t        kind,
  output logic [2*REG_W-1:0] word
);

  localparam int SPAN = 2 * REG_W;
  localparam int SW   = $clog2(SPAN + 1);
  // Compare in a width wide enough for both the raw amount and SPAN.
  localparam int AW   = (REG_W > SW) ? REG_W : SW;

  logic [AW-1:0] amount_ext;
  logic [SW-1:0] amt;

  assign amount_ext = AW'(amount);
  assign amt        = (amount_ext >= AW'(SPAN)) ? SW'(SPAN) : SW'(amount_ext);

  always_comb begin
    word = '0;
    case (kind)
      SH_LEFT: word = {{REG_W{1'b0}}, data} << amt;
      SH_SRL:  word = {data, {REG_W{1'b0}}} >> amt;
      // A shift by the full 2W width fills the word with the sign bit.
      SH_SRA:  word = $signed({data, {REG_W{1'b0}}}) >>> amt;
      default: word = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Registered arithmetic/logic unit of the CPU datapath.
//                One-cycle latency, one operation per cycle, no handshake.
//  Ports       : clk    rising-edge clock
//                reset  asynchronous active-high reset, clears all outputs
//                bus    alu_if.slave: ra_in, rb_in, op in;
//                       res_out, car_out, zero, jump out (all registered)
//  Revision    : 1.0  initial release
// ============================================================================
module alu
  import alu_pkg::*;
#(
  parameter int REG_W = REG_WIDTH
) (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);

  alu_op_t            opc;
  logic [REG_W:0]     sum;
  logic [REG_W:0]     diff;
  logic               borrow;
  shift_kind_t        kind;
  logic [2*REG_W-1:0] shifted;
  logic [REG_W-1:0]   res_nxt;
  logic [REG_W-1:0]   car_nxt;
  logic               jump_nxt;

  assign opc    = alu_op_t'(bus.op);
  assign sum    = {1'b0, bus.ra_in} + {1'b0, bus.rb_in};
  // Zero-extended subtract: the extra top bit is set exactly when ra < rb.
  assign diff   = {1'b0, bus.ra_in} - {1'b0, bus.rb_in};
  assign borrow = diff[REG_W];

  always_comb begin
    kind = SH_SRL;
    case (opc)
      OP_SLL:  kind = SH_LEFT;
      OP_SRA:  kind = SH_SRA;
      default: kind = SH_SRL;
    endcase
  end

  alu_shifter #(
    .REG_W (REG_W)
  ) u_shifter (
    .data   (bus.ra_in),
    .amount (bus.rb_in),
    .kind   (kind),
    .word   (shifted)
  );

  always_comb begin
    res_nxt  = '0;
    car_nxt  = '0;
    jump_nxt = 1'b0;
    case (opc)
      OP_ADD: begin
        res_nxt = sum[REG_W-1:0];
        car_nxt = REG_W'(sum[REG_W]);
      end
      OP_SUB: begin
        res_nxt = diff[REG_W-1:0];
        car_nxt = REG_W'(borrow);
      end
      OP_SLL: begin
        res_nxt = shifted[REG_W-1:0];
        car_nxt = shifted[2*REG_W-1:REG_W];
      end
      // Right shifts keep the result in the upper half of the word.
      OP_SRL, OP_SRA: begin
        res_nxt = shifted[2*REG_W-1:REG_W];
        car_nxt = shifted[REG_W-1:0];
      end
      OP_AND: res_nxt = bus.ra_in & bus.rb_in;
      OP_XOR: res_nxt = bus.ra_in ^ bus.rb_in;
      OP_BEQ: begin
        res_nxt  = diff[REG_W-1:0];
        car_nxt  = REG_W'(borrow);
        jump_nxt = (bus.ra_in == bus.rb_in);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.res_out <= '0;
      bus.car_out <= '0;
      bus.zero    <= 1'b0;
      bus.jump    <= 1'b0;
    end else begin
      bus.res_out <= res_nxt;
      bus.car_out <= car_nxt;
      bus.zero    <= (res_nxt == '0);
      bus.jump    <= jump_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu
//  Description : Directed self-checking bench for alu. Inputs change on the
//                falling edge, outputs are sampled 1 ns after the rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input alu_op_t o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.op    = o;
    bus.ra_in = a;
    bus.rb_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] er, input logic [7:0] ec,
                       input logic ez, input logic ej);
    logic [17:0] got;
    logic [17:0] want;
    got  = {bus.res_out, bus.car_out, bus.zero, bus.jump};
    want = {er, ec, ez, ej};
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: res/car/zero/jump got %h/%h/%b/%b want %h/%h/%b/%b",
             tag, got[17:10], got[9:2], got[1], got[0], er, ec, ez, ej);
    end
  endtask

  initial begin
    logic [7:0] amts    [7];
    logic [7:0] srl_res [7];
    logic [7:0] srl_car [7];
    logic [7:0] sra_car [7];
    amts    = '{8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14, 8'd16};
    srl_res = '{8'h0F, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    srl_car = '{8'h00, 8'hC0, 8'hF0, 8'h3C, 8'h0F, 8'h03, 8'h00};
    sra_car = '{8'h00, 8'hC0, 8'hF0, 8'hFC, 8'hFF, 8'hFF, 8'hFF};

    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    bus.op    = OP_ADD;
    bus.ra_in = 8'd0;
    bus.rb_in = 8'd0;
    #2;
    check("reset_initial", 8'h00, 8'h00, 1'b0, 1'b0);

    // Release reset, then run ADD 5+3 and hit it with reset mid-cycle.
    @(negedge clk);
    reset = 1'b0;
    drive(OP_ADD, 8'd5, 8'd3);
    check("add_5_3", 8'h08, 8'h00, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("add_after_reset", 8'h08, 8'h00, 1'b0, 1'b0);

    // Inputs changed mid-cycle must not disturb registered outputs.
    bus.op    = OP_XOR;
    bus.ra_in = 8'h11;
    #2;
    check("hold_mid_cycle", 8'h08, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      drive(OP_SRL, 8'hF0, amts[i]);
      check($sformatf("srl_%0d", amts[i]), srl_res[i], srl_car[i], (srl_res[i] == 8'h00), 1'b0);
    end
    for (int i = 0; i < 7; i++) begin
      drive(OP_SRA, 8'hF0, amts[i]);
      check($sformatf("sra_%0d", amts[i]), 8'hFF, sra_car[i], 1'b0, 1'b0);
    end
    drive(OP_SRA, 8'h70, 8'd4);   check("sra_pos",     8'h07, 8'h00, 1'b0, 1'b0);
    drive(OP_SRA, 8'h80, 8'hFF);  check("sra_sat",     8'hFF, 8'hFF, 1'b0, 1'b0);
    drive(OP_SRL, 8'h5A, 8'd0);   check("srl_zero_n",  8'h5A, 8'h00, 1'b0, 1'b0);
    drive(OP_SLL, 8'h81, 8'd1);   check("sll_1",       8'h02, 8'h01, 1'b0, 1'b0);
    drive(OP_SLL, 8'hAB, 8'hFF);  check("sll_sat",     8'h00, 8'h00, 1'b1, 1'b0);
    drive(OP_SLL, 8'hAB, 8'd12);  check("sll_12",      8'h00, 8'hB0, 1'b1, 1'b0);
    drive(OP_ADD, 8'hFF, 8'h01);  check("add_wrap",    8'h00, 8'h01, 1'b1, 1'b0);
    drive(OP_SUB, 8'h03, 8'h05);  check("sub_borrow",  8'hFE, 8'h01, 1'b0, 1'b0);
    drive(OP_SUB, 8'h05, 8'h03);  check("sub_plain",   8'h02, 8'h00, 1'b0, 1'b0);
    drive(OP_AND, 8'hF0, 8'h3C);  check("and",         8'h30, 8'h00, 1'b0, 1'b0);
    drive(OP_XOR, 8'hAA, 8'hAA);  check("xor_zero",    8'h00, 8'h00, 1'b1, 1'b0);
    drive(OP_XOR, 8'hA5, 8'h0F);  check("xor",         8'hAA, 8'h00, 1'b0, 1'b0);
    drive(OP_BEQ, 8'h42, 8'h42);  check("beq_taken",   8'h00, 8'h00, 1'b1, 1'b1);
    drive(OP_BEQ, 8'h42, 8'h41);  check("beq_not",     8'h01, 8'h00, 1'b0, 1'b0);
    drive(OP_BEQ, 8'h41, 8'h42);  check("beq_borrow",  8'hFF, 8'h01, 1'b0, 1'b0);
    drive(OP_SUB, 8'h42, 8'h42);  check("sub_eq_nojmp", 8'h00, 8'h00, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
